alu_seq_core: RTL and testbench
===============================

Name: alu_seq_core

Overview:
Handshaked, multi-cycle successor to the combinational per-operation ALU circuits. It covers the logic, bit-shift, arithmetic and comparison classes in one block with a parametrised word width and a half-word/full-word mode. It holds a persistent status register (zero/sign/carry), and the carry bit feeds ADC/SBC. Shifts and rotates by a variable amount run one bit per cycle. The block sits between the decode stage and register write-back.

Parameters:
WIDTH, 20, datapath width in bits; even, >= 4; half-word width H = WIDTH/2
SHAMT_W, $clog2(WIDTH), width of the shift-amount field taken from b

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept a request
op  in  5  opcode (see Behaviour)
mode  in  1  1 = full-word (WIDTH bits), 0 = half-word (low H bits)
a  in  WIDTH  operand A
b  in  WIDTH  operand B; b[SHAMT_W-1:0] is the shift amount
out_valid  out  1  result available
out_ready  in  1  consumer accepts result
result  out  WIDTH  primary result
result_b  out  WIDTH  secondary result (SWP only, else 0)
flags  out  3  {sign, zero, carry}, a copy of the status register

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=0 while in reset, then 1; out_valid=0; result=0; result_b=0; status register=0. Reset mid-operation aborts the operation with no output.
- States:
  - IDLE: in_ready=1. A transfer (in_valid & in_ready) latches op, mode, a, b. Shift/rotate with nonzero amount, or MUL, goes to EXEC; all other ops go to DONE.
  - EXEC: one bit-step per cycle, then DONE.
  - DONE: out_valid=1. result, result_b and flags are stable until out_ready. out_valid & out_ready returns to IDLE.
- Latency from the accept edge to out_valid: 1 cycle for single-cycle ops; 1 + n for shifts by n; 1 + H for MUL. in_ready=0 outside IDLE.
- Half-word mode: operate on a[H-1:0] and b[H-1:0]. Result upper half = 0. Flags come from the H-bit result. Carry comes from bit H.
- Opcodes:
  - 0 NOT; 1 AND; 2 OR; 3 XOR.
  - 4 SHR; 5 SHL; 6 ROR; 7 ROL.
  - 8 SWP: result=b, result_b=a.
  - 9 INC; 10 DEC.
  - 11 ADD; 12 ADC (+carry); 13 SUB; 14 SBC (-carry).
  - 15 CMP: a-b, flags only; result=a.
  - 16 MUL (optional feature).
  - Any other opcode: NOP; result=a, status unchanged.
- Shift amount = b[SHAMT_W-1:0] mod effective width. Amount 0 takes 1 cycle: result = a, carry cleared for shifts.
- Carry rules:
  - SHR/SHL: carry = last bit shifted out.
  - ROR/ROL: carry unchanged.
  - Add-type ops: carry = carry out.
  - Subtract-type ops (SUB, SBC, DEC, CMP): carry = borrow (1 when the minuend is less than the subtrahend, unsigned).
  - Logic ops and SWP: carry unchanged.
- zero = effective result == 0. sign = effective result MSB. Both are updated by every defined op except NOP; SWP flags come from result.
- Status register loads on entry to DONE. A following ADC/SBC therefore always sees the previous op's carry.
- Arithmetic wraps modulo 2^effective width.

Optional Feature:
ALU_SEQ_MUL_EN
- Defined: op 16 = unsigned a[H-1:0] * b[H-1:0] giving a WIDTH-bit product by shift-add, H cycles in EXEC. mode is ignored. Carry is cleared; zero and sign come from the full product.
- Undefined: op 16 is a NOP and no multiplier logic is built.

Decomposition:
- Package alu_seq_pkg: opcode localparams (OP_NOT..OP_MUL), state encoding (ST_IDLE, ST_EXEC, ST_DONE), flag bit indices (FLG_CARRY=0, FLG_ZERO=1, FLG_SIGN=2).
- Sub-module alu_seq_shifter: iterative one-bit shift/rotate unit (load, step, done, last_out), parametrised by WIDTH, with mode handling.

Test Plan:
1. WIDTH=20, ADD full, a=0xFFFFF, b=0x00001 -> result=0x00000, zero=1, carry=1, sign=0, out_valid 1 cycle after accept.
2. Next op ADC full, a=0x00002, b=0x00003 -> result=0x00006, carry=0; then SUB a=1, b=2 -> result=0xFFFFF, carry=1, sign=1.
3. SHL half, a=0x00080, b=3 -> result=0x00000, carry=1, zero=1, out_valid 4 cycles after accept; ROR full, a=0x00001, b=1 -> 0x80000, sign=1, latency 2.
4. Backpressure: out_ready=0 for 5 cycles after out_valid -> result/flags held, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
5. rst_n pulsed low mid-EXEC of a SHR by 7 -> out_valid=0 immediately, flags=0; after release in_ready=1, and the next ADD a=1, b=1 gives result 2.
6. With ALU_SEQ_MUL_EN: MUL, a=0x003FF, b=0x003FF -> result=0xFF801, sign=1, latency 11. Without it: result=a, flags unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// ============================================================================
// alu_seq_pkg : opcodes, FSM state encoding and flag bit positions for alu_seq_core
// Rev 1.0
// ============================================================================
`default_nettype none

package alu_seq_pkg;

    localparam logic [4:0] OP_NOT = 5'd0;
    localparam logic [4:0] OP_AND = 5'd1;
    localparam logic [4:0] OP_OR  = 5'd2;
    localparam logic [4:0] OP_XOR = 5'd3;
    localparam logic [4:0] OP_SHR = 5'd4;
    localparam logic [4:0] OP_SHL = 5'd5;
    localparam logic [4:0] OP_ROR = 5'd6;
    localparam logic [4:0] OP_ROL = 5'd7;
    localparam logic [4:0] OP_SWP = 5'd8;
    localparam logic [4:0] OP_INC = 5'd9;
    localparam logic [4:0] OP_DEC = 5'd10;
    localparam logic [4:0] OP_ADD = 5'd11;
    localparam logic [4:0] OP_ADC = 5'd12;
    localparam logic [4:0] OP_SUB = 5'd13;
    localparam logic [4:0] OP_SBC = 5'd14;
    localparam logic [4:0] OP_CMP = 5'd15;
    localparam logic [4:0] OP_MUL = 5'd16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int FLG_CARRY = 0;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_SIGN  = 2;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == OP_SHR) || (op == OP_SHL) || (op == OP_ROR) || (op == OP_ROL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_shifter.sv
// ============================================================================
// alu_seq_shifter : iterative one-bit-per-step shift/rotate unit, full or half word
// Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq_shifter #(
    parameter int WIDTH   = 20,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               mode,
    input  logic               left,
    input  logic               rotate,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] amt,
    output logic [WIDTH-1:0]   step_data,
    output logic               last_out,
    output logic               done
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_cnt;
    logic               r_mode;
    logic               r_left;
    logic               r_rotate;
    logic               w_out;

    // step_data / last_out describe the value after the step taken this cycle
    always_comb begin
        w_out     = 1'b0;
        step_data = r_data;
        if (r_left) begin
            w_out     = r_mode ? r_data[WIDTH-1] : r_data[H-1];
            step_data = {r_data[WIDTH-2:0], r_rotate & w_out};
            if (!r_mode) begin
                step_data[WIDTH-1:H] = '0;
            end
        end else begin
            w_out     = r_data[0];
            step_data = {1'b0, r_data[WIDTH-1:1]};
            if (r_mode) begin
                step_data[WIDTH-1] = r_rotate & w_out;
            end else begin
                step_data[H-1] = r_rotate & w_out;
            end
        end
    end

    assign last_out = w_out;
    assign done     = (r_cnt == SHAMT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data   <= '0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_left   <= 1'b0;
            r_rotate <= 1'b0;
        end else if (load) begin
            r_data   <= data_in;
            r_cnt    <= amt;
            r_mode   <= mode;
            r_left   <= left;
            r_rotate <= rotate;
        end else if (step) begin
            r_data <= step_data;
            r_cnt  <= r_cnt - SHAMT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_seq_core.sv
// ============================================================================
// alu_seq_core : handshaked multi-cycle ALU with persistent {sign,zero,carry} status
// Optional ALU_SEQ_MUL_EN adds an H-cycle shift-add multiplier on op 16.  Rev 1.0
// ============================================================================
`default_nettype none

module alu_seq_core #(
    parameter int WIDTH   = 20,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_b,
    output logic [2:0]       flags
);

    import alu_seq_pkg::*;

    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0]   c_half_mask = {{(WIDTH - H){1'b0}}, {H{1'b1}}};
    localparam logic [SHAMT_W:0]   c_width_ext = (SHAMT_W + 1)'(WIDTH);
    localparam logic [SHAMT_W:0]   c_half_ext  = (SHAMT_W + 1)'(H);
    localparam logic [SHAMT_W-1:0] c_h_amt     = SHAMT_W'(H);

    logic [1:0]       r_state;
    logic [4:0]       r_op;
    logic             r_mode;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_b;
    logic [2:0]       r_status;

    logic [WIDTH-1:0]   w_mask, w_am, w_bm;
    logic [SHAMT_W:0]   w_amt_ext;
    logic [SHAMT_W-1:0] w_amt, w_sh_amt;
    logic               w_accept, w_shift_go, w_mul_go, w_sh_load, w_sh_step;
    logic [WIDTH:0]     w_add, w_sub;
    logic [WIDTH-1:0]   w_add_b, w_sub_b, w_sub_m;
    logic               w_add_c, w_sub_c, w_add_co, w_sub_bo;
    logic [WIDTH-1:0]   w_sc_result, w_sc_result_b, w_sc_fsrc;
    logic               w_sc_carry, w_sc_upd;
    logic [2:0]         w_sc_status;
    logic [WIDTH-1:0]   w_ex_result;
    logic [2:0]         w_ex_status;
    logic               w_ex_carry;
    logic [WIDTH-1:0]   w_sh_data;
    logic               w_sh_last, w_sh_done;

    // operand v is already masked to the effective width
    function automatic logic [2:0] mk_flags(input logic [WIDTH-1:0] v, input logic full,
                                            input logic c);
        logic [2:0] f;
        f[FLG_CARRY] = c;
        f[FLG_ZERO]  = (v == '0);
        f[FLG_SIGN]  = full ? v[WIDTH-1] : v[H-1];
        return f;
    endfunction

    assign in_ready  = rst_n && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign result    = r_result;
    assign result_b  = r_result_b;
    assign flags     = r_status;

    assign w_accept  = in_valid && in_ready;
    assign w_mask    = mode ? {WIDTH{1'b1}} : c_half_mask;
    assign w_am      = a & w_mask;
    assign w_bm      = b & w_mask;
    assign w_amt_ext = {1'b0, b[SHAMT_W-1:0]} % (mode ? c_width_ext : c_half_ext);
    assign w_amt     = SHAMT_W'(w_amt_ext);

    assign w_shift_go = is_shift(op) && (w_amt != '0);
`ifdef ALU_SEQ_MUL_EN
    assign w_mul_go = (op == OP_MUL);
`else
    assign w_mul_go = 1'b0;
`endif
    assign w_sh_load = w_accept && (w_shift_go || w_mul_go);
    assign w_sh_step = (r_state == ST_EXEC);
    assign w_sh_amt  = w_mul_go ? c_h_amt : w_amt;

    // Half-word operands are zero-extended, so bit H carries the carry/borrow out
    assign w_add_b  = (op == OP_INC) ? WIDTH'(1) : w_bm;
    assign w_add_c  = (op == OP_ADC) ? r_status[FLG_CARRY] : 1'b0;
    assign w_add    = {1'b0, w_am} + {1'b0, w_add_b} + (WIDTH + 1)'(w_add_c);
    assign w_sub_b  = (op == OP_DEC) ? WIDTH'(1) : w_bm;
    assign w_sub_c  = (op == OP_SBC) ? r_status[FLG_CARRY] : 1'b0;
    assign w_sub    = {1'b0, w_am} - {1'b0, w_sub_b} - (WIDTH + 1)'(w_sub_c);
    assign w_add_co = mode ? w_add[WIDTH] : w_add[H];
    assign w_sub_bo = mode ? w_sub[WIDTH] : w_sub[H];
    assign w_sub_m  = w_sub[WIDTH-1:0] & w_mask;

    always_comb begin
        w_sc_result   = w_am;
        w_sc_result_b = '0;
        w_sc_carry    = r_status[FLG_CARRY];
        w_sc_upd      = 1'b1;
        case (op)
            OP_NOT: w_sc_result = ~w_am & w_mask;
            OP_AND: w_sc_result = w_am & w_bm;
            OP_OR:  w_sc_result = w_am | w_bm;
            OP_XOR: w_sc_result = w_am ^ w_bm;
            OP_SHR, OP_SHL: w_sc_carry = 1'b0;
            OP_ROR, OP_ROL: w_sc_carry = r_status[FLG_CARRY];
            OP_SWP: begin
                w_sc_result   = w_bm;
                w_sc_result_b = w_am;
            end
            OP_INC, OP_ADD, OP_ADC: begin
                w_sc_result = w_add[WIDTH-1:0] & w_mask;
                w_sc_carry  = w_add_co;
            end
            OP_DEC, OP_SUB, OP_SBC: begin
                w_sc_result = w_sub_m;
                w_sc_carry  = w_sub_bo;
            end
            OP_CMP: w_sc_carry = w_sub_bo;
            default: w_sc_upd = 1'b0;
        endcase
        w_sc_fsrc   = (op == OP_CMP) ? w_sub_m : w_sc_result;
        w_sc_status = w_sc_upd ? mk_flags(w_sc_fsrc, mode, w_sc_carry) : r_status;
    end

    alu_seq_shifter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_sh_load),
        .step      (w_sh_step),
        .mode      (mode),
        .left      ((op == OP_SHL) || (op == OP_ROL)),
        .rotate    ((op == OP_ROR) || (op == OP_ROL)),
        .data_in   (w_mul_go ? '0 : w_am),
        .amt       (w_sh_amt),
        .step_data (w_sh_data),
        .last_out  (w_sh_last),
        .done      (w_sh_done)
    );

`ifdef ALU_SEQ_MUL_EN
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mcand;
    logic [H-1:0]     r_mplier;
    logic [WIDTH-1:0] w_acc_next;

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (w_accept && w_mul_go) begin
            r_acc    <= '0;
            r_mcand  <= {{(WIDTH - H){1'b0}}, a[H-1:0]};
            r_mplier <= b[H-1:0];
        end else if ((r_state == ST_EXEC) && (r_op == OP_MUL)) begin
            r_acc    <= w_acc_next;
            r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[H-1:1]};
        end
    end
`endif

    assign w_ex_carry = ((r_op == OP_ROR) || (r_op == OP_ROL)) ? r_status[FLG_CARRY]
                                                               : w_sh_last;

    always_comb begin
        w_ex_result = w_sh_data;
        w_ex_status = mk_flags(w_sh_data, r_mode, w_ex_carry);
`ifdef ALU_SEQ_MUL_EN
        if (r_op == OP_MUL) begin
            w_ex_result = w_acc_next;
            w_ex_status = mk_flags(w_acc_next, 1'b1, 1'b0);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_op       <= '0;
            r_mode     <= 1'b0;
            r_result   <= '0;
            r_result_b <= '0;
            r_status   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op   <= op;
                        r_mode <= mode;
                        if (w_shift_go || w_mul_go) begin
                            r_state <= ST_EXEC;
                        end else begin
                            r_state    <= ST_DONE;
                            r_result   <= w_sc_result;
                            r_result_b <= w_sc_result_b;
                            r_status   <= w_sc_status;
                        end
                    end
                end
                ST_EXEC: begin
                    // final step lands directly in the result/status registers
                    if (w_sh_done) begin
                        r_state    <= ST_DONE;
                        r_result   <= w_ex_result;
                        r_result_b <= '0;
                        r_status   <= w_ex_status;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_core.sv
// ============================================================================
// tb_alu_seq_core : directed plan steps plus random ops against an arithmetic reference
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_alu_seq_core;

    localparam int W  = 20;
    localparam int HW = W / 2;
    localparam int SW = $clog2(W);

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [W-1:0] result_b;
    logic [2:0]   flags;

    int           checks;
    int           errors;
    logic [2:0]   m_status;
    logic [W-1:0] g_res;
    logic [2:0]   g_flags;
    logic [2:0]   prev_flags;
    int           g_lat;

    always #5 clk = ~clk;

    alu_seq_core #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_b  (result_b),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the effective-width values.
    // Status layout {sign, zero, carry}.
    function automatic void ref_op(input int opc, input bit md, input longint av,
                                   input longint bv, input logic [2:0] st,
                                   output longint r, output longint rb,
                                   output logic [2:0] st_o, output int lat);
        longint ew, modv, am, bm, fv, t, fw;
        int     n;
        bit     c, upd;
        ew   = md ? W : HW;
        modv = longint'(1) << ew;
        am   = av % modv;
        bm   = bv % modv;
        n    = int'((bv % (longint'(1) << SW)) % ew);
        r    = am;
        rb   = 0;
        lat  = 1;
        c    = st[0];
        upd  = 1'b1;
        fw   = ew;
        case (opc)
            0:  r = modv - 1 - am;
            1:  r = am & bm;
            2:  r = am | bm;
            3:  r = am ^ bm;
            4: begin
                r = am >> n; lat = 1 + n;
                c = (n == 0) ? 1'b0 : (((am >> (n - 1)) & 1) != 0);
            end
            5: begin
                r = (am << n) % modv; lat = 1 + n;
                c = (n == 0) ? 1'b0 : (((am >> (ew - n)) & 1) != 0);
            end
            6: begin
                r = (n == 0) ? am : (((am >> n) | (am << (ew - n))) % modv); lat = 1 + n;
            end
            7: begin
                r = (n == 0) ? am : (((am << n) | (am >> (ew - n))) % modv); lat = 1 + n;
            end
            8: begin r = bm; rb = am; end
            9: begin t = am + 1; r = t % modv; c = (t >= modv); end
            10: begin c = (am < 1); r = (am - 1 + modv) % modv; end
            11: begin t = am + bm; r = t % modv; c = (t >= modv); end
            12: begin t = am + bm + longint'(st[0]); r = t % modv; c = (t >= modv); end
            13: begin c = (am < bm); r = (am - bm + modv) % modv; end
            14: begin t = bm + longint'(st[0]); c = (am < t); r = (am - t + modv) % modv; end
            15: c = (am < bm);
`ifdef ALU_SEQ_MUL_EN
            16: begin
                r = (av % (longint'(1) << HW)) * (bv % (longint'(1) << HW));
                c = 1'b0; lat = 1 + HW; fw = W;
            end
`endif
            default: upd = 1'b0;
        endcase
        fv   = (opc == 15) ? ((am - bm + modv) % modv) : r;
        st_o = upd ? {(((fv >> (fw - 1)) & 1) != 0), (fv == 0), c} : st;
    endfunction

    task automatic run_op(input int opc, input bit md, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input int hold);
        longint     er, erb;
        logic [2:0] est;
        int         elat;
        int         lat;
        bit         seen;
        ref_op(opc, md, longint'(av), longint'(bv), m_status, er, erb, est, elat);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = 5'(opc);
        mode      = md;
        a         = av;
        b         = bv;
        out_ready = 1'b0;
        check("idle_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        lat  = 0;
        seen = 1'b0;
        while (lat < 64 && !seen) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (out_valid) seen = 1'b1;
            else check("busy_in_ready", 64'(in_ready), 64'd0);
        end
        check("out_valid_seen", 64'(seen), 64'd1);
        check("latency", 64'(lat), 64'(elat));
        check("result", 64'(result), 64'(er));
        check("result_b", 64'(result_b), 64'(erb));
        check("flags", 64'(flags), 64'(est));
        g_res    = result;
        g_flags  = flags;
        g_lat    = lat;
        m_status = est;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_result", 64'(result), 64'(er));
            check("hold_flags", 64'(flags), 64'(est));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_status  = 3'b000;
        in_valid  = 1'b0;
        op        = 5'd0;
        mode      = 1'b0;
        a         = '0;
        b         = '0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_result", 64'(result), 64'd0);
        check("post_rst_result_b", 64'(result_b), 64'd0);
        check("post_rst_flags", 64'(flags), 64'd0);

        run_op(11, 1'b1, 20'hFFFFF, 20'h00001, 0);
        check("tp_add_res", 64'(g_res), 64'h00000);
        check("tp_add_flags", 64'(g_flags), 64'b011);
        check("tp_add_lat", 64'(g_lat), 64'd1);
        run_op(12, 1'b1, 20'h00002, 20'h00003, 0);
        check("tp_adc_res", 64'(g_res), 64'h00006);
        check("tp_adc_flags", 64'(g_flags), 64'b000);
        run_op(13, 1'b1, 20'h00001, 20'h00002, 0);
        check("tp_sub_res", 64'(g_res), 64'hFFFFF);
        check("tp_sub_flags", 64'(g_flags), 64'b101);
        run_op(5, 1'b0, 20'h00080, 20'h00003, 0);
        check("tp_shl_res", 64'(g_res), 64'h00000);
        check("tp_shl_flags", 64'(g_flags), 64'b011);
        check("tp_shl_lat", 64'(g_lat), 64'd4);
        run_op(6, 1'b1, 20'h00001, 20'h00001, 0);
        check("tp_ror_res", 64'(g_res), 64'h80000);
        check("tp_ror_flags", 64'(g_flags), 64'b101);
        check("tp_ror_lat", 64'(g_lat), 64'd2);
        run_op(3, 1'b1, W'($urandom), W'($urandom), 5);

        // reset in the middle of a 7-step SHR
        @(negedge clk);
        in_valid = 1'b1; op = 5'd4; mode = 1'b1; a = W'($urandom); b = 20'h00007;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_exec_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'(out_valid), 64'd0);
        check("abort_flags", 64'(flags), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_release_in_ready", 64'(in_ready), 64'd1);
        m_status = 3'b000;
        run_op(11, 1'b1, 20'h00001, 20'h00001, 0);
        check("tp_after_rst_add", 64'(g_res), 64'h00002);

        prev_flags = m_status;
        run_op(16, 1'b1, 20'h003FF, 20'h003FF, 0);
`ifdef ALU_SEQ_MUL_EN
        check("tp_mul_res", 64'(g_res), 64'hFF801);
        check("tp_mul_sign", 64'(g_flags[2]), 64'd1);
        check("tp_mul_lat", 64'(g_lat), 64'd11);
`else
        check("tp_mul_nop_res", 64'(g_res), 64'h003FF);
        check("tp_mul_nop_flags", 64'(g_flags), 64'(prev_flags));
`endif

        for (int k = 0; k < 150; k++) begin
            run_op(int'($urandom_range(0, 17)), 1'($urandom_range(0, 1)),
                   W'($urandom), W'($urandom), int'($urandom_range(0, 2)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
